rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
- N-way round-robin arbiter that shares one downstream resource (bus, memory port, FIFO write side) between N requesters.
- Grants are registered.
- A granted requester holds the resource until it drops its request or completes MAX_BURST accepted beats.
- The pointer then advances past the owner, and the grant hands over with no bubble cycle.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_BURST, 4, maximum accepted beats per grant before forced release (MAX_BURST >= 1).
- IDW, $clog2(N), width of grant_id (localparam, not overridable).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- requests  input  N  per-requester request level; held high while the requester has data.
- ready  input  1  resource accepts a beat this cycle.
- grants  output  N  registered one-hot grant; all-zero when idle.
- grant_id  output  IDW  index of the current owner; 0 when idle.
- busy  output  1  high when any grant is active.
- beat  output  1  combinational: busy & ready & requests[grant_id].

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - grants=0, grant_id=0, busy=0, state=IDLE.
  - ptr=0, beat_cnt=0.
- Picker (combinational):
  - sel = first set bit of requests scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - any = |requests.
- States:
  - IDLE: grants=0. At the edge where any=1, go to BUSY with owner=sel, grants=onehot(sel), beat_cnt=0. Latency from request to grant is 1 cycle.
  - BUSY: on a beat, beat_cnt increments.
- Release condition, evaluated in BUSY each cycle:
  - requests[owner]==0, or
  - beat && beat_cnt==MAX_BURST-1.
- On release:
  - ptr <= owner+1, wrapping N-1 to 0.
  - The next owner is picked in the same edge, using the new ptr and the current requests.
  - If another requester exists, grants switch directly to it. There is no idle cycle.
  - If only the old owner still requests (burst-limit case), it is re-granted with beat_cnt=0.
  - If no request is present, go to IDLE.
- No preemption: a newly arriving request never changes grants while the owner holds.
- ready=0 stalls: beat_cnt holds and the grant holds indefinitely while the owner keeps requesting.
- A request dropping while ready=1 is not counted as a beat.
- MAX_BURST=1: every accepted beat releases. This gives pure per-beat round-robin.
- The pointer advances only on release, never in IDLE.
- beat_cnt width: max(1,$clog2(MAX_BURST)).
- Reset mid-burst: everything clears asynchronously; after reset, arbitration restarts from ptr=0.

Optional Feature:
- Macro: RR_BURST_ARBITER_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1 in BUSY, the burst-limit release is suppressed and beat_cnt saturates at MAX_BURST-1.
  - Release by request drop still occurs.
  - lock is ignored in IDLE.
- Not defined: no lock port; behaviour is identical to lock=0.

Decomposition:
- Package rr_arb_pkg contains:
  - typedef enum logic {IDLE, BUSY} rr_arb_state_t;
  - a function onehot_to_index for grant_id consistency checks in the bench.
- One sub-module, rr_pick, is natural.
  - Purely combinational; parameter N.
  - Inputs: requests, ptr.
  - Outputs: any, sel (IDW bits).
  - Instantiated once. The release path feeds it owner+1 as ptr.

Test Plan:
- Reset: hold rst=0 with requests=1111, ready=1 -> grants=0000, grant_id=0, busy=0. Release reset -> first edge grants=0001.
- Fair rotation: N=4, MAX_BURST=4, requests=1111, ready=1 -> grants 0001 ×4, 0010 ×4, 0100 ×4, 1000 ×4, 0001 … with no zero cycles between owners.
- Sole requester: requests=0010, ready=1 -> grants=0010 continuously; beat_cnt runs 0,1,2,3,0,… (re-grant at each burst end).
- Stall and drop: requests=0101, ready=0 -> grants=0001 held 20 cycles with beat_cnt=0. Drop requests[0] -> next edge grants=0100, ptr=1.
- Wrap: owner 3 with requests=1001 releases by burst limit -> grants=0001, ptr=0. All requests dropped -> grants=0000 next edge, busy=0.
- Async reset mid-burst: assert rst=0 between edges while grants=0100 -> grants=0000 immediately. With RR_BURST_ARBITER_LOCK_EN and lock=1, requests=0011 -> owner 0 keeps the grant beyond 4 beats until requests[0]=0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// The lock feature is selected by the RR_BURST_ARBITER_LOCK_EN macro in rr_burst_arbiter.
package rr_arb_pkg;

   typedef enum logic {IDLE, BUSY} rr_arb_state_t;

   // Index of the highest set bit; for a one-hot vector this is its position.
   function automatic int onehot_to_index(input logic [31:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Used by rr_burst_arbiter (optional lock feature: RR_BURST_ARBITER_LOCK_EN).
module rr_pick #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   requests,
   input  logic [IDW-1:0] ptr,
   output logic           any,
   output logic [IDW-1:0] sel
);

   int             idx;
   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      any   = |requests;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         cand = IDW'(idx);
         if (!found && requests[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-way round-robin arbiter with bounded bursts and bubble-free handover.
// Optional macro RR_BURST_ARBITER_LOCK_EN adds a lock input that suppresses burst-limit release.
//
// state | meaning
// IDLE  | no grant; next edge grants the picker's choice from ptr if anyone requests
// BUSY  | grant_id owns the resource until request drop or MAX_BURST beats
module rr_burst_arbiter
   import rr_arb_pkg::*;
#(
   parameter  int N         = 4,
   parameter  int MAX_BURST = 4,
   localparam int IDW       = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   requests,
   input  logic           ready,
`ifdef RR_BURST_ARBITER_LOCK_EN
   input  logic           lock,
`endif
   output logic [N-1:0]   grants,
   output logic [IDW-1:0] grant_id,
   output logic           busy,
   output logic           beat
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
   localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

   rr_arb_state_t  state;
   logic [IDW-1:0] ptr;
   logic [CW-1:0]  beat_cnt;

   logic           lock_eff;
   logic           owner_req;
   logic           at_limit;
   logic           release_now;
   logic [IDW-1:0] owner_next;
   logic [IDW-1:0] pick_ptr;
   logic           pick_any;
   logic [IDW-1:0] pick_sel;

`ifdef RR_BURST_ARBITER_LOCK_EN
   assign lock_eff = lock;
`else
   assign lock_eff = 1'b0;
`endif

   assign owner_req   = requests[grant_id];
   assign beat        = busy & ready & owner_req;
   assign at_limit    = (beat_cnt == CNT_LAST);
   assign release_now = !owner_req || (beat && at_limit && !lock_eff);
   assign owner_next  = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;

   // While busy the picker only matters on release, where it must start past the owner.
   assign pick_ptr = (state == BUSY) ? owner_next : ptr;

   rr_pick #(.N(N)) u_pick (
      .requests (requests),
      .ptr      (pick_ptr),
      .any      (pick_any),
      .sel      (pick_sel)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         beat_cnt <= '0;
         grants   <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state    <= BUSY;
                  grant_id <= pick_sel;
                  grants   <= ONE << pick_sel;
                  busy     <= 1'b1;
                  beat_cnt <= '0;
               end
            end
            BUSY: begin
               if (release_now) begin
                  ptr      <= owner_next;
                  beat_cnt <= '0;
                  if (pick_any) begin
                     grant_id <= pick_sel;
                     grants   <= ONE << pick_sel;
                  end else begin
                     state    <= IDLE;
                     grant_id <= '0;
                     grants   <= '0;
                     busy     <= 1'b0;
                  end
               end else if (beat && !at_limit) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
               // A beat at the limit without release only happens under lock: saturate.
            end
            default: begin
               state    <= IDLE;
               grants   <= '0;
               grant_id <= '0;
               busy     <= 1'b0;
               beat_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-free behavioural owner/pointer/count model.
module tb_rr_burst_arbiter;

   localparam int N    = 4;
   localparam int MAXB = 4;
   localparam int IDW  = $clog2(N);

   logic           clk;
   logic           rst;
   logic [N-1:0]   requests;
   logic           ready;
   logic [N-1:0]   grants;
   logic [IDW-1:0] grant_id;
   logic           busy;
   logic           beat;

   int total;
   int passed;

   // Model: owner (-1 when idle), round-robin start pointer, beats taken in this grant.
   int m_owner;
   int m_ptr;
   int m_cnt;

   rr_burst_arbiter #(.N(N), .MAX_BURST(MAXB)) dut (
      .clk      (clk),
      .rst      (rst),
      .requests (requests),
      .ready    (ready),
      .grants   (grants),
      .grant_id (grant_id),
      .busy     (busy),
      .beat     (beat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int first_from(input logic [N-1:0] req, input int start);
      for (int i = 0; i < N; i++) begin
         if (req[(start + i) % N]) return (start + i) % N;
      end
      return -1;
   endfunction

   function automatic logic [31:0] model_grants();
      return (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
   endfunction

   function automatic logic model_beat();
      return (m_owner >= 0) && ready && requests[m_owner];
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   // One rising edge of the arbitration rules, using the inputs held across that edge.
   task automatic model_edge();
      logic took_beat;
      if (m_owner < 0) begin
         if (requests != '0) begin
            m_owner = first_from(requests, m_ptr);
            m_cnt   = 0;
         end
      end else begin
         took_beat = model_beat();
         if (!requests[m_owner] || (took_beat && m_cnt == MAXB - 1)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = first_from(requests, m_ptr);
            m_cnt   = 0;
         end else if (took_beat) begin
            m_cnt++;
         end
      end
   endtask

   task automatic check_outputs();
      check("grants", 32'(grants), model_grants());
      check("grant_id", 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      if (busy)
         check("grant_id_vs_onehot", 32'(grant_id),
               32'(rr_arb_pkg::onehot_to_index(32'(grants))));
   endtask

   // Inputs are driven just after a rising edge; beat is checked mid-cycle, state after the edge.
   task automatic step();
      @(negedge clk);
      check("beat", 32'(beat), 32'(model_beat()));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   initial begin
      total    = 0;
      passed   = 0;
      rst      = 1'b0;
      requests = 4'b1111;
      ready    = 1'b1;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("reset_grants", 32'(grants), 32'h0);
      check("reset_grant_id", 32'(grant_id), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      rst = 1'b1;

      // Fair rotation: four grants per owner, no idle cycle between owners.
      for (int k = 0; k < 17; k++) begin
         step();
         check("rotation", 32'(grants), 32'd1 << ((k / 4) % 4));
      end

      // Sole requester: owner 0 drops, requester 1 is re-granted every burst.
      requests = 4'b0010;
      for (int k = 0; k < 12; k++) begin
         step();
         check("sole", 32'(grants), 32'h2);
      end

      requests = 4'b0100;
      step();
      check("to_owner2", 32'(grants), 32'h4);

      // Asynchronous reset between edges.
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check("async_rst_grants", 32'(grants), 32'h0);
      check("async_rst_busy", 32'(busy), 32'h0);
      #1;
      rst = 1'b1;

      // Stall: owner 0 holds with ready low, then drops and hands to 2 (ptr restarts at 1).
      requests = 4'b0101;
      ready    = 1'b0;
      for (int k = 0; k < 21; k++) begin
         step();
         check("stall_hold", 32'(grants), 32'h1);
      end
      requests = 4'b0100;
      step();
      check("drop_handover", 32'(grants), 32'h4);

      requests = 4'b1000;
      step();
      check("to_owner3", 32'(grants), 32'h8);

      // Wrap: owner 3 hits the burst limit and hands over to 0.
      requests = 4'b1001;
      ready    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("wrap_hold", 32'(grants), 32'h8);
      end
      step();
      check("wrap_handover", 32'(grants), 32'h1);

      requests = 4'b0000;
      step();
      check("all_drop_grants", 32'(grants), 32'h0);
      check("all_drop_busy", 32'(busy), 32'h0);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 2) == 0) requests = requests ^ (4'b0001 << $urandom_range(0, N - 1));
         if ($urandom_range(0, 63) == 0) requests = 4'b0000;
         if ($urandom_range(0, 31) == 0) requests = 4'b1111;
         ready = ($urandom_range(0, 3) != 0);
         if (c == 1500) begin
            #2;
            rst = 1'b0;
            #1;
            model_reset();
            check("rand_async_rst", 32'(busy), 32'h0);
            #1;
            rst = 1'b1;
         end
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
